m_frame_buf: RTL and testbench
==============================

M_FRAME_BUF -- requirements
Module: m_frame_buf

Interface
REQ-001 Parameters SHALL be:
- DW, default 32, width of each real and imaginary component.
- N, default 8, points per frame; power of two, at least 2.
- AW, default $clog2(N), derived index width; SHALL NOT be overridden.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  buffer can accept a sample.
- in_data  in  2*DW  sample; [2*DW-1:DW] real, [DW-1:0] imaginary.
- out_valid  out  1  complete frame presented.
- out_ready  in  1  consumer releases the presented frame.
- out_re  out  N*DW  real parts; point k at [k*DW+DW-1:k*DW].
- out_im  out  N*DW  imaginary parts; same packing as out_re.
- wr_cnt  out  AW  samples already accepted into the frame being filled.

Function
REQ-003 Storage SHALL be two banks of N complex entries, used ping-pong.
REQ-004 Control state SHALL be: wr_bank (1 bit), rd_bank (1 bit), full[1:0], wr_cnt (AW bits).
REQ-005 Output relations:
- in_ready = !full[wr_bank].
- out_valid = full[rd_bank].
REQ-006 Input accept occurs on a rising edge with in_valid && in_ready. It SHALL:
- write in_data to bank wr_bank at index f(wr_cnt);
- increment wr_cnt modulo N.
REQ-007 On the accept with wr_cnt == N-1, on the same edge:
- full[wr_bank] SHALL set;
- wr_bank SHALL toggle;
- wr_cnt SHALL wrap to 0.
REQ-008 out_valid SHALL assert in the cycle after the edge accepting the Nth sample when rd_bank is the bank just filled; latency is 1 cycle.
REQ-009 out_re/out_im SHALL present bank rd_bank with no extra register stage, and SHALL stay stable while out_valid is high.
REQ-010 Output handshake occurs on a rising edge with out_valid && out_ready. It SHALL clear full[rd_bank] and toggle rd_bank.
REQ-011 Simultaneous frame completion and output handshake on the same edge SHALL both take effect, because they act on different banks.
REQ-012 Back-pressure:
- With both banks full, in_ready SHALL be 0.
- in_data SHALL be ignored and no state SHALL change on the input side.
REQ-013 A consumer that accepts each frame within N cycles SHALL sustain one sample per cycle with in_ready never dropping.
REQ-014 in_valid while in_ready is 0 SHALL NOT corrupt stored data or counters.
REQ-015 out_ready while out_valid is 0 SHALL have no effect.

Reset
REQ-016 On rst_n low, asynchronously:
- wr_bank, rd_bank, full and wr_cnt SHALL clear;
- all storage entries SHALL clear to 0.
REQ-017 Output values during reset:
- in_ready = 1;
- out_valid = 0;
- out_re and out_im = 0;
- wr_cnt = 0.
REQ-018 Reset mid-frame SHALL discard the partial frame and any presented frame; the first accept after release SHALL write index f(0) of bank 0.

Configuration
REQ-019 Macro M_FRAME_BUF_BITREV_EN SHALL select the index mapping f:
- defined: f(k) = k with its AW bits reversed (bit-reversed store for radix-2 FFT input ordering);
- undefined: f(k) = k, natural order.
REQ-020 Handshake timing, latency and wr_cnt counting SHALL be identical with and without the macro.

Verification (N=8, DW=32)
REQ-021 Single frame, macro undefined: send samples re=k, im=100+k for k=0..7, out_ready=0 -> out_valid=1 one cycle after 8th accept; point k reads re=k, im=100+k; wr_cnt back to 0.
REQ-022 Bit-reverse, macro defined: same stimulus as REQ-021 -> point 1 holds re=4; point 3 holds re=6; point 6 holds re=3.
REQ-023 Back-pressure: out_ready=0, in_valid held high for 20 cycles -> exactly 16 accepts; in_ready=0 from cycle 17; presented frame unchanged.
REQ-024 Streaming: in_valid=1 and out_ready=1 continuously for 64 cycles -> in_ready stays 1; 8 frames output, first at cycle 9, then one every 8 cycles.
REQ-025 Reset mid-operation: rst_n low after 5 accepts, released 2 cycles later -> outputs 0 and wr_cnt=0; next 8 samples form a correct frame in bank 0.
REQ-026 Simultaneous events: assert out_ready on the edge that accepts the last sample of the second frame -> frame 1 released and frame 2 presented on the next cycle; out_valid stays 1.

Source files
------------

// File: rtl/m_frame_buf.sv
// m_frame_buf: ping-pong complex frame buffer, N points per frame presented in parallel.
// Define M_FRAME_BUF_BITREV_EN to store samples at bit-reversed indices (FFT input order).
module m_frame_buf #(
  parameter int DW = 32,
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_re,
  output logic [N*DW-1:0] out_im,
  output logic [AW-1:0]   wr_cnt
);
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [DW-1:0] re_q [2][N];
  logic [DW-1:0] im_q [2][N];
  logic          accept, release_frame;
  logic [AW-1:0] wr_idx;

  function automatic logic [AW-1:0] f_idx(input logic [AW-1:0] k);
    logic [AW-1:0] r;
`ifdef M_FRAME_BUF_BITREV_EN
    for (int b = 0; b < AW; b++) r[b] = k[AW-1-b];
`else
    r = k;
`endif
    return r;
  endfunction

  assign in_ready      = !full_q[wr_bank_q];
  assign out_valid     = full_q[rd_bank_q];
  assign wr_cnt        = wr_cnt_q;
  assign accept        = in_valid && in_ready;
  assign release_frame = out_valid && out_ready;
  assign wr_idx        = f_idx(wr_cnt_q);

  // Completion and release always target different banks, so both may apply on one edge.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    wr_cnt_d  = wr_cnt_q;
    if (accept) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == AW'(N-1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (release_frame) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      wr_cnt_q  <= '0;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < N; k++) begin
          re_q[b][k] <= '0;
          im_q[b][k] <= '0;
        end
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      wr_cnt_q  <= wr_cnt_d;
      if (accept) begin
        re_q[wr_bank_q][wr_idx] <= in_data[2*DW-1:DW];
        im_q[wr_bank_q][wr_idx] <= in_data[DW-1:0];
      end
    end
  end

  always_comb begin
    out_re = '0;
    out_im = '0;
    for (int k = 0; k < N; k++) begin
      out_re[k*DW +: DW] = re_q[rd_bank_q][k];
      out_im[k*DW +: DW] = im_q[rd_bank_q][k];
    end
  end
endmodule

// File: tb/tb_m_frame_buf.sv
// tb_m_frame_buf: directed table-driven and sequence checks for m_frame_buf (N=8, DW=32).
module tb_m_frame_buf;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [2*DW-1:0] in_data = '0;
  logic            in_ready, out_valid;
  logic [N*DW-1:0] out_re, out_im;
  logic [AW-1:0]   wr_cnt;
  int passed = 0;
  int total  = 0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          e_ir;
    logic          e_ov;
    logic [AW-1:0] e_wc;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  m_frame_buf #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .wr_cnt(wr_cnt)
  );

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int fidx(input int k);
`ifdef M_FRAME_BUF_BITREV_EN
    int r = 0;
    for (int b = 0; b < AW; b++) r |= ((k >> b) & 1) << (AW - 1 - b);
    return r;
`else
    return k;
`endif
  endfunction

  function automatic logic [N*DW-1:0] frame(input int base);
    logic [N*DW-1:0] v = '0;
    for (int k = 0; k < N; k++) v[fidx(k)*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int re, input int im);
    in_valid = 1'b1;
    in_data  = {DW'(re), DW'(im)};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int acc, frames, first, ir_bad, sp_bad;
    for (int k = 0; k < 8; k++) begin
      tbl[k].iv = 1'b1; tbl[k].re = DW'(k); tbl[k].im = DW'(100 + k);
      tbl[k].e_ir = 1'b1; tbl[k].e_ov = (k == 7); tbl[k].e_wc = AW'((k + 1) % 8);
    end
    for (int k = 8; k < 10; k++) begin
      tbl[k].iv = 1'b0; tbl[k].re = '0; tbl[k].im = '0;
      tbl[k].e_ir = 1'b1; tbl[k].e_ov = 1'b1; tbl[k].e_wc = '0;
    end

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, '0);
    chk("rst_out_im", out_im, '0);
    chk("rst_wr_cnt", wr_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].iv;
      in_data  = {tbl[i].re, tbl[i].im};
      tick();
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_wr_cnt", i), wr_cnt, tbl[i].e_wc);
    end
    in_valid = 1'b0;
    chk("single_re", out_re, frame(0));
    chk("single_im", out_im, frame(100));

    do_reset();
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = {DW'(200 + c), DW'(300 + c)};
      if (in_ready) acc++;
      tick();
      if (c == 15) chk("bp_in_ready_c17", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc, 16);
    chk("bp_re", out_re, frame(200));
    chk("bp_im", out_im, frame(300));
    chk("bp_wr_cnt", wr_cnt, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_re", out_re, frame(208));
    chk("bp_next_in_ready", in_ready, 1);

    do_reset();
    for (int k = 0; k < 8; k++) send(400 + k, 450 + k);
    for (int k = 0; k < 5; k++) send(410 + k, 460 + k);
    chk("mid_pre_wr_cnt", wr_cnt, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_re", out_re, '0);
    chk("mid_rst_im", out_im, '0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_wr_cnt", wr_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_ready_no_effect", out_valid, 0);
    for (int k = 0; k < 8; k++) send(50 + k, 150 + k);
    chk("mid_post_valid", out_valid, 1);
    chk("mid_post_re", out_re, frame(50));
    chk("mid_post_im", out_im, frame(150));

    do_reset();
    frames = 0; first = 0; ir_bad = 0; sp_bad = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      in_data = {DW'(c - 1), DW'(1000 + c - 1)};
      tick();
      if (!in_ready) ir_bad++;
      if (out_valid) begin
        frames++;
        if (frames == 1) first = c;
        if (c % 8 != 0) sp_bad++;
        chk($sformatf("stream_f%0d_re", frames), out_re, frame(8 * (frames - 1)));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("stream_first", first, 8);
    chk("stream_frames", frames, 8);
    chk("stream_in_ready_drops", ir_bad, 0);
    chk("stream_spacing", sp_bad, 0);

    do_reset();
    for (int k = 0; k < 8; k++) send(500 + k, 550 + k);
    for (int k = 0; k < 7; k++) send(600 + k, 650 + k);
    chk("sim_pre_in_ready", in_ready, 1);
    chk("sim_pre_re", out_re, frame(500));
    in_valid  = 1'b1;
    in_data   = {DW'(607), DW'(657)};
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("sim_valid", out_valid, 1);
    chk("sim_re", out_re, frame(600));
    chk("sim_im", out_im, frame(650));
    chk("sim_in_ready", in_ready, 1);
    chk("sim_wr_cnt", wr_cnt, 0);
    tick();
    chk("sim_hold_valid", out_valid, 1);
    chk("sim_hold_re", out_re, frame(600));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
